// File: rtl/burst_enable_gen_if.sv
// Handshake/configuration bundle between a sequence controller (master)
// and the burst enable generator (slave).
interface burst_enable_gen_if #(
  parameter int LEN_W = 8,
  parameter int NUM_W = 8
);

  // Controller -> generator
  logic             start;
  logic             stop;
  logic [LEN_W-1:0] burst_len;
  logic [LEN_W-1:0] gap_len;
  logic [NUM_W-1:0] num_bursts;

  // Generator -> controller / downstream counter
  logic             enable;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [NUM_W-1:0] bursts_done;

  modport master (
    output start, stop, burst_len, gap_len, num_bursts,
    input  enable, busy, done, aborted, bursts_done
  );

  modport slave (
    input  start, stop, burst_len, gap_len, num_bursts,
    output enable, busy, done, aborted, bursts_done
  );

endinterface

// File: rtl/burst_enable_gen.sv
// Burst enable sequencer: on an accepted start it drives a downstream
// up-counter's enable with num_bursts runs of burst_len high cycles,
// separated by gap_len low cycles. num_bursts == 0 runs until stop.
// Every output is a flop, so there is no input-to-output timing path.
module burst_enable_gen #(
  parameter int LEN_W = 8,
  parameter int NUM_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  burst_enable_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_GAP,
    S_DONE
  } state_t;

  // Configuration captured on an accepted start; inputs may change freely
  // afterwards without disturbing the running sequence.
  typedef struct packed {
    logic [LEN_W-1:0] burst_len;
    logic [LEN_W-1:0] gap_len;
    logic [NUM_W-1:0] num_bursts;
  } cfg_t;

  localparam logic [NUM_W-1:0] BD_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

  state_t           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  // Single down-counter shared by BURST and GAP: loaded with (length - 1)
  // on entry, the phase ends on the cycle it reads zero. This gives exactly
  // `length` cycles for every value 1..2^LEN_W-1 without overflow.
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] bd_q, bd_d;
  logic             aborted_q, aborted_d;
  logic             enable_q, busy_q, done_q;

  logic [NUM_W-1:0] bd_inc;
  logic             final_burst;

  // Saturating increment of the completed-burst count and final-burst detect.
  always_comb begin
    bd_inc      = (bd_q == BD_MAX) ? bd_q : bd_q + NUM_ONE;
    final_burst = (cfg_q.num_bursts != '0) && (bd_inc == cfg_q.num_bursts);
  end

  // Next-state, counter, burst count and abort flag.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    cfg_d     = cfg_q;
    cnt_d     = cnt_q;
    bd_d      = bd_q;
    aborted_d = aborted_q;

    unique case (state_q)
      S_IDLE: begin
        // stop is deliberately ignored here.
        if (bus.start) begin
          cfg_d     = '{burst_len:  bus.burst_len,
                        gap_len:    bus.gap_len,
                        num_bursts: bus.num_bursts};
          bd_d      = '0;
          aborted_d = 1'b0;
          if (bus.burst_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BURST;
            cnt_d   = bus.burst_len - LEN_ONE;
          end
        end
      end

      S_BURST: begin
        if (cnt_q == '0) begin
          // Last enable cycle of this burst: it counts even if stop
          // arrives on the same edge.
          bd_d = bd_inc;
          if (bus.stop) begin
            state_d   = S_DONE;
            aborted_d = 1'b1;
          end else if (final_burst) begin
            state_d = S_DONE;
          end else if (cfg_q.gap_len == '0) begin
            state_d = S_BURST;
            cnt_d   = cfg_q.burst_len - LEN_ONE;
          end else begin
            state_d = S_GAP;
            cnt_d   = cfg_q.gap_len - LEN_ONE;
          end
        end else if (bus.stop) begin
          // Partial burst is dropped from the count.
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else begin
          cnt_d = cnt_q - LEN_ONE;
        end
      end

      S_GAP: begin
        if (bus.stop) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_BURST;
          cnt_d   = cfg_q.burst_len - LEN_ONE;
        end else begin
          cnt_d = cnt_q - LEN_ONE;
        end
      end

      S_DONE: begin
        // Single-cycle completion state; start and stop both ignored.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, configuration and status registers; outputs are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the latched configuration is cleared as well, not just the
      // control state, so no stale burst/gap length survives a reset.
      state_q   <= S_IDLE;
      cfg_q     <= '0;
      cnt_q     <= '0;
      bd_q      <= '0;
      aborted_q <= 1'b0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      bd_q      <= bd_d;
      aborted_q <= aborted_d;
      enable_q  <= (state_d == S_BURST);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign bus.enable      = enable_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.bursts_done = bd_q;

endmodule

// File: tb/tb_burst_enable_gen.sv
// Self-checking bench for burst_enable_gen. Each sequence pushes its
// expected per-cycle enable/busy/done pattern and a completion record
// (bursts_done, aborted, downstream count) into queues; a negedge monitor
// pops and compares them as the DUT runs.
module tb_burst_enable_gen;

  localparam int LEN_W = 8;
  localparam int NUM_W = 8;
  localparam int CNT_W = 8;   // width of the modelled downstream counter
  localparam int BD_SAT = (1 << NUM_W) - 1;
  localparam int MAX_CYC = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  burst_enable_gen_if #(.LEN_W(LEN_W), .NUM_W(NUM_W)) bus ();

  burst_enable_gen #(.LEN_W(LEN_W), .NUM_W(NUM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int   cyc;
    logic en;
    logic busy;
    logic done;
  } cyc_exp_t;

  typedef struct {
    int   bursts;
    logic aborted;
    int   count;
  } seq_exp_t;

  cyc_exp_t exp_q[$];
  seq_exp_t seq_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Downstream enable-gated up-counter, cleared when a sequence is launched.
  logic [CNT_W-1:0] ds_cnt;
  logic             ds_clr = 1'b1;

  always @(posedge clk) begin
    if (ds_clr)          ds_cnt <= '0;
    else if (bus.enable) ds_cnt <= ds_cnt + 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expand a sequence into its expected cycle pattern. Cycle 0 is the cycle
  // in which start is high; abort_at (0 = none) is the cycle stop is high.
  task automatic build(input int len, input int gap, input int num, input int abort_at);
    int c   = 0;
    int nb  = 0;
    int ens = 0;
    bit fin = 0;
    bit ab  = 0;
    exp_q.push_back('{0, 1'b0, 1'b0, 1'b0});
    fin = (len == 0);
    while (!fin) begin
      for (int i = 0; i < len && !fin; i++) begin
        c++;
        ens++;
        exp_q.push_back('{c, 1'b1, 1'b1, 1'b0});
        if (i == len - 1) nb = (nb == BD_SAT) ? BD_SAT : nb + 1;
        if (c == abort_at) begin ab = 1; fin = 1; end
      end
      if (!fin && num != 0 && nb == num) fin = 1;
      for (int i = 0; i < gap && !fin; i++) begin
        c++;
        exp_q.push_back('{c, 1'b0, 1'b1, 1'b0});
        if (c == abort_at) begin ab = 1; fin = 1; end
      end
    end
    c++;
    exp_q.push_back('{c, 1'b0, 1'b1, 1'b1});
    c++;
    exp_q.push_back('{c, 1'b0, 1'b0, 1'b0});
    seq_q.push_back('{nb, ab, ens % (1 << CNT_W)});
  endtask

  task automatic monitor_cycle();
    cyc_exp_t e;
    seq_exp_t s;
    e = exp_q.pop_front();
    check($sformatf("enable@c%0d", e.cyc), 32'(bus.enable), 32'(e.en));
    check($sformatf("busy@c%0d", e.cyc),   32'(bus.busy),   32'(e.busy));
    check($sformatf("done@c%0d", e.cyc),   32'(bus.done),   32'(e.done));
    if (e.done) begin
      if (seq_q.size() != 0) begin
        s = seq_q.pop_front();
        check("bursts_done", 32'(bus.bursts_done), 32'(s.bursts));
        check("aborted",     32'(bus.aborted),     32'(s.aborted));
        check("ds_count",    32'(ds_cnt),          32'(s.count));
      end else begin
        check("seq_record", 32'(seq_q.size()), 32'd1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) monitor_cycle();
  end

  // Launch one sequence; busy_start_at (0 = none) pulses start with a
  // different configuration in that cycle, which must be ignored.
  task automatic run_seq(input int len, input int gap, input int num,
                         input int abort_at, input int busy_start_at);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.burst_len  = LEN_W'(len);
    bus.gap_len    = LEN_W'(gap);
    bus.num_bursts = NUM_W'(num);
    ds_clr         = 1'b1;
    build(len, gap, num, abort_at);
    for (int k = 1; k < MAX_CYC && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
      ds_clr    = 1'b0;
      bus.start = (k == busy_start_at);
      if (k == busy_start_at) begin
        bus.burst_len  = LEN_W'(7);
        bus.gap_len    = LEN_W'(1);
        bus.num_bursts = NUM_W'(9);
      end
      bus.stop = (k == abort_at);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("seq_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    seq_q.delete();
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.burst_len  = '0;
    bus.gap_len    = '0;
    bus.num_bursts = '0;

    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    ds_clr = 1'b0;

    // Reset state and idle behaviour with stop toggling.
    @(negedge clk);
    check("rst_enable",  32'(bus.enable),      32'd0);
    check("rst_busy",    32'(bus.busy),        32'd0);
    check("rst_done",    32'(bus.done),        32'd0);
    check("rst_aborted", 32'(bus.aborted),     32'd0);
    check("rst_bursts",  32'(bus.bursts_done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.stop = ((i % 2) == 0);
      @(negedge clk);
      check("idle_enable", 32'(bus.enable), 32'd0);
      check("idle_busy",   32'(bus.busy),   32'd0);
      check("idle_done",   32'(bus.done),   32'd0);
    end
    bus.stop = 1'b0;

    // Basic 3/2/2 pattern, then bursts_done holds in idle.
    run_seq(3, 2, 2, 0, 0);
    @(negedge clk);
    check("bd_hold", 32'(bus.bursts_done), 32'd2);

    // Back-to-back bursts, zero-length burst, maximum burst length.
    run_seq(4, 0, 3, 0, 0);
    run_seq(0, 0, 5, 0, 0);
    run_seq(255, 0, 2, 0, 0);

    // Start (with new configuration) while busy in a gap cycle is ignored.
    run_seq(3, 2, 2, 0, 4);

    // Infinite run aborted in the 2nd cycle of the 3rd burst; aborted holds.
    run_seq(5, 3, 0, 18, 0);
    @(negedge clk);
    check("aborted_hold", 32'(bus.aborted), 32'd1);

    // bursts_done saturation over 300 one-cycle bursts.
    run_seq(1, 0, 0, 300, 0);

    // stop on the last cycle of the final burst still counts it and aborts.
    run_seq(2, 1, 2, 5, 0);

    // Reset in idle clears the held aborted flag.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_rst_aborted", 32'(bus.aborted), 32'd0);

    // Reset mid-burst: len 1, no gap, infinite, so bursts_done is non-zero.
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.burst_len  = LEN_W'(1);
    bus.gap_len    = LEN_W'(0);
    bus.num_bursts = NUM_W'(0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_enable", 32'(bus.enable),      32'd1);
    check("pre_rst_bursts", 32'(bus.bursts_done), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_enable",  32'(bus.enable),      32'd0);
    check("mid_rst_busy",    32'(bus.busy),        32'd0);
    check("mid_rst_done",    32'(bus.done),        32'd0);
    check("mid_rst_aborted", 32'(bus.aborted),     32'd0);
    check("mid_rst_bursts",  32'(bus.bursts_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Recovery after reset.
    run_seq(2, 1, 1, 0, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_enable_gen.md
Name: burst_enable_gen

Overview:
- Programmable enable sequencer that sits directly upstream of the enable-gated up-counter and drives that counter's enable input.
- On a start request it issues a configurable number of bursts. Each burst is a run of consecutive single-cycle enable highs, and bursts are separated by a configurable idle gap.
- It reports busy, completion, abort and a completed-burst count, so a bench or controller can predict the downstream count value exactly.

Parameters:
- LEN_W, 8, width of burst_len, gap_len and the internal burst/gap cycle counters.
- NUM_W, 8, width of num_bursts and bursts_done.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request to begin a sequence; sampled only in IDLE.
- stop  input  1  abort request; sampled only while busy.
- burst_len  input  LEN_W  enable-high cycles per burst; latched on accepted start.
- gap_len  input  LEN_W  enable-low cycles between bursts; latched on accepted start.
- num_bursts  input  NUM_W  bursts per sequence; 0 = run until stop; latched on accepted start.
- enable  output  1  registered enable to the downstream counter.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse when a sequence ends, either normally or by abort.
- aborted  output  1  valid with done; 1 = ended by stop.
- bursts_done  output  NUM_W  completed full bursts in the current or last sequence.

Behaviour:
- Reset, when rst_n is low at a rising edge:
  - State goes to IDLE.
  - enable, busy, done, aborted and bursts_done all go to 0.
  - Latched configuration is cleared.
  - Reset takes priority over every other input, including mid-burst; enable is low from the next cycle onward.
- All outputs are registered; there is no combinational input-to-output path.
- States: IDLE, BURST, GAP, DONE.
- IDLE:
  - start=1 at edge t latches the configuration and clears bursts_done to 0.
  - If burst_len==0, go to DONE at t: done=1 at t+1 with no enables, aborted=0.
  - Otherwise go to BURST, with enable=1 and busy=1 from t+1.
  - stop is ignored in IDLE.
  - A start while busy is ignored and has no effect on the latched configuration.
- BURST:
  - enable stays high for exactly burst_len consecutive cycles.
  - On the last cycle, bursts_done increments; the new value is visible the cycle after.
  - If the increment makes bursts_done equal num_bursts (num_bursts != 0), go to DONE; no gap follows the final burst.
  - Otherwise, if gap_len==0, start the next burst back-to-back (enable stays high continuously).
  - Otherwise go to GAP.
- GAP: enable stays low for exactly gap_len cycles, then return to BURST.
- DONE:
  - Lasts one cycle, with done=1, busy=1, enable=0.
  - The next state is IDLE; busy falls the following cycle.
  - A start can be accepted in the first IDLE cycle after DONE.
- stop while busy (BURST or GAP), sampled at edge t:
  - Go to DONE, with enable=0 from t+1, done=1 and aborted=1 at t+1.
  - A partial burst is not counted in bursts_done.
  - If stop is sampled on the same edge as a burst's last cycle, the burst counts, and stop still forces aborted=1 even if that was the final burst.
- stop is ignored in DONE.
- aborted holds its value until the next accepted start clears it.
- num_bursts==0 means infinite operation. bursts_done saturates at all-ones and does not wrap.
- Counter arithmetic is unsigned, LEN_W/NUM_W bits. Maximum values, e.g. burst_len=255 with LEN_W=8, must produce exactly 255 enable cycles with no off-by-one and no wrap.
- Downstream invariant: the number of enable-high cycles in a normal sequence equals burst_len*num_bursts. With the downstream counter starting at 0, its final count equals that product mod 2^WIDTH.

Test Plan:
- Reset, then idle for 5 cycles -> enable/busy/done/bursts_done all 0; toggling stop in IDLE changes nothing.
- Start with burst_len=3, gap_len=2, num_bursts=2, sampled at edge 0:
  - enable high in cycles 1-3 and 6-8, low in cycles 4-5.
  - done=1 in cycle 9, aborted=0, bursts_done=2.
  - busy high in cycles 1-9.
  - Downstream counter ends at 6.
- Start with burst_len=4, gap_len=0, num_bursts=3 -> enable high continuously for 12 cycles, then done; counter reads 12.
- Start with burst_len=0, num_bursts=5 -> done=1 one cycle after start, enable never high, bursts_done=0.
- Start with burst_len=5, gap_len=3, num_bursts=0; assert stop in the 2nd cycle of the 3rd burst -> enable low next cycle, done=1 and aborted=1 together, bursts_done=2.
- Drive rst_n low mid-burst, and separately assert start while busy -> reset gives all outputs 0 the next cycle; a start while busy leaves the pattern and latched configuration unchanged.
